alu_mc: RTL and testbench

- Parametrised, registered successor to the combinational integer ALU in the RISC-V core's execute stage.
- Adds a valid/ready handshake on input and output, corrected status flags, SLT/SLTU, and an iterative RV32M multiply/divide unit that takes multiple cycles.
- Sits between decode/issue and writeback. The issue stage stalls on in_ready; writeback consumes results on out_valid/out_ready.

---
 rtl/alu_mc.sv | 198 +++++++++++++++++++
 tb/tb_alu_mc.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: registered execute-stage ALU with valid/ready handshakes and status flags.
// Define ALU_MC_MDU_EN to build the iterative RV32M multiply/divide unit; otherwise ops 10-17 are illegal.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       status,
    output logic             illegal
);
    localparam logic [4:0] OP_ADD  = 5'h00, OP_SUB    = 5'h01, OP_AND   = 5'h02, OP_OR    = 5'h03;
    localparam logic [4:0] OP_XOR  = 5'h04, OP_SLL    = 5'h05, OP_SRL   = 5'h06, OP_SRA   = 5'h07;
    localparam logic [4:0] OP_SLT  = 5'h08, OP_SLTU   = 5'h09, OP_MUL   = 5'h10, OP_MULH  = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12, OP_MULHU = 5'h13, OP_DIV  = 5'h14, OP_DIVU  = 5'h15;
    localparam logic [4:0] OP_REM  = 5'h16, OP_REMU   = 5'h17;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_status;
    logic             r_illegal;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_lt;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ill;
    logic             w_multi;

    assign in_ready  = rst_n && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign status    = r_status;
    assign illegal   = r_illegal;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_lt   = $signed(a) < $signed(b);
    assign w_sh   = b[SHW-1:0];

`ifdef ALU_MC_MDU_EN
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    logic [WIDTH-1:0]   r_hi, r_lo, r_m;
    logic [4:0]         r_op;
    logic               r_neg;
    logic [SHW:0]       r_cnt;

    logic               w_b_zero, w_ovf, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_q, w_r, w_fix;
    logic [WIDTH:0]     w_mul_sum, w_trial;
    logic [2*WIDTH-1:0] w_prod;

    assign w_b_zero = (b == {WIDTH{1'b0}});
    assign w_ovf    = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
    assign w_a_sgn  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign w_b_sgn  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign w_a_neg  = w_a_sgn & a[WIDTH-1];
    assign w_b_neg  = w_b_sgn & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;
    // Remainder follows the dividend's sign; product and quotient follow the sign product.
    assign w_neg    = (op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_mul_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_m : {WIDTH{1'b0}})};
    assign w_trial   = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_m};
    assign w_prod    = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_q       = r_neg ? -r_lo : r_lo;
    assign w_r       = r_neg ? -r_hi : r_hi;

    // Final sign-corrected M-extension result selection.
    always_comb begin
        w_fix = {WIDTH{1'b0}};
        case (r_op)
            OP_MUL:                       w_fix = w_prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              w_fix = w_q;
            OP_REM, OP_REMU:              w_fix = w_r;
            default:                      w_fix = {WIDTH{1'b0}};
        endcase
    end
`endif

    // Single-cycle result, flags, and multi-cycle dispatch decision.
    always_comb begin
        w_res   = {WIDTH{1'b0}};
        w_carry = 1'b0;
        w_ill   = 1'b0;
        w_multi = 1'b0;
        case (op)
            OP_ADD:  begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
            OP_SUB:  begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_SLL:  w_res = a << w_sh;
            OP_SRL:  w_res = a >> w_sh;
            OP_SRA:  w_res = $unsigned($signed(a) >>> w_sh);
            OP_SLT:  begin w_res = {{(WIDTH-1){1'b0}}, w_lt};        w_carry = w_lt;         end
            OP_SLTU: begin w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]}; w_carry = w_diff[WIDTH]; end
`ifdef ALU_MC_MDU_EN
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: w_multi = 1'b1;
            OP_DIV:  begin
                w_res   = w_b_zero ? {WIDTH{1'b1}} : a;
                w_multi = !w_b_zero && !w_ovf;
            end
            OP_DIVU: begin w_res = {WIDTH{1'b1}}; w_multi = !w_b_zero; end
            OP_REM:  begin
                w_res   = w_b_zero ? a : {WIDTH{1'b0}};
                w_multi = !w_b_zero && !w_ovf;
            end
            OP_REMU: begin w_res = a; w_multi = !w_b_zero; end
`endif
            default: w_ill = 1'b1;
        endcase
    end

    // Control FSM with registered result, status and illegal outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_status    <= 2'b00;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept && w_multi) begin
`ifdef ALU_MC_MDU_EN
                        r_op  <= op;
                        r_hi  <= {WIDTH{1'b0}};
                        r_lo  <= w_a_mag;
                        r_m   <= w_b_mag;
                        r_neg <= w_neg;
                        r_cnt <= {(SHW+1){1'b0}};
`endif
                        r_state     <= BUSY;
                        r_out_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_res;
                        r_status    <= {w_carry, (w_res == {WIDTH{1'b0}})};
                        r_illegal   <= w_ill;
                    end else if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
`ifdef ALU_MC_MDU_EN
                BUSY: begin
                    if (r_cnt != CNT_LAST) begin
                        r_cnt <= r_cnt + CNT_ONE;
                        if (r_op[2]) begin
                            r_hi <= w_trial[WIDTH] ? {r_hi[WIDTH-2:0], r_lo[WIDTH-1]} : w_trial[WIDTH-1:0];
                            r_lo <= {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};
                        end else begin
                            r_hi <= w_mul_sum[WIDTH:1];
                            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                        end
                    end else begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_fix;
                        r_status    <= {1'b0, (w_fix == {WIDTH{1'b0}})};
                        r_illegal   <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed vectors push expectations, a monitor pops on each new result.
module tb_alu_mc;
`ifdef ALU_MC_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif
    localparam int LM = MDU ? 33 : 0;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [4:0]  op;
    logic [31:0] a, b, result;
    logic [1:0]  status;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .status(status), .illegal(illegal)
    );

    typedef struct {
        logic [31:0] res;
        logic [1:0]  st;
        logic        ill;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare each newly presented result against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && !seen) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got out_valid=1 result=%h expected no pending result", result);
            end else begin
                e = sb.pop_front();
                chk({e.name, ".result"}, result, e.res);
                chk({e.name, ".status"}, {30'd0, status}, {30'd0, e.st});
                chk({e.name, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
                chk({e.name, ".latency"}, 32'(cyc - e.acc), 32'(e.lat));
            end
            seen = 1'b1;
        end
        if (!out_valid || out_ready) seen = 1'b0;
    end

    task automatic issue(input string name, input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] er, input logic [1:0] es, input logic ei, input int el, input bit push);
        int tries = 0;
        op = o; a = va; b = vb; in_valid = 1'b1;
        while (!in_ready && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.accept: got in_ready=0 expected 1 within 100 cycles", name);
            in_valid = 1'b0;
            return;
        end
        if (push) sb.push_back('{er, es, ei, el, cyc + 1, name});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int t;
        bit rose;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 5'h00; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.status", {30'd0, status}, 32'd0);
        chk("rst.illegal", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue("add",  5'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 2'b11, 1'b0, 0, 1'b1);
        chk("add.b2b_in_ready", {31'd0, in_ready}, 32'd1);
        issue("sub",  5'h01, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 2'b10, 1'b0, 0, 1'b1);
        issue("and",  5'h02, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 2'b00, 1'b0, 0, 1'b1);
        issue("or",   5'h03, 32'h0F0F0000, 32'h0000F0F0, 32'h0F0FF0F0, 2'b00, 1'b0, 0, 1'b1);
        issue("xor",  5'h04, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 2'b00, 1'b0, 0, 1'b1);
        issue("sll",  5'h05, 32'h00000001, 32'h00000021, 32'h00000002, 2'b00, 1'b0, 0, 1'b1);
        issue("srl",  5'h06, 32'h80000000, 32'h0000003F, 32'h00000001, 2'b00, 1'b0, 0, 1'b1);
        issue("sra",  5'h07, 32'h80000000, 32'h00000024, 32'hF8000000, 2'b00, 1'b0, 0, 1'b1);
        issue("slt",  5'h08, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 2'b10, 1'b0, 0, 1'b1);
        issue("sltu", 5'h09, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 2'b01, 1'b0, 0, 1'b1);
        issue("ill1f", 5'h1F, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 2'b01, 1'b1, 0, 1'b1);

        issue("div",   5'h14, 32'hFFFFFFF9, 32'h00000002, MDU ? 32'hFFFFFFFD : 32'h0, MDU ? 2'b00 : 2'b01, !MDU, LM, 1'b1);
        issue("rem",   5'h16, 32'hFFFFFFF9, 32'h00000002, MDU ? 32'hFFFFFFFF : 32'h0, MDU ? 2'b00 : 2'b01, !MDU, LM, 1'b1);
        issue("divu0", 5'h15, 32'h12345678, 32'h00000000, MDU ? 32'hFFFFFFFF : 32'h0, MDU ? 2'b00 : 2'b01, !MDU, 0, 1'b1);
        issue("rem0",  5'h16, 32'hFFFFFFF9, 32'h00000000, MDU ? 32'hFFFFFFF9 : 32'h0, MDU ? 2'b00 : 2'b01, !MDU, 0, 1'b1);
        issue("divov", 5'h14, 32'h80000000, 32'hFFFFFFFF, MDU ? 32'h80000000 : 32'h0, MDU ? 2'b00 : 2'b01, !MDU, 0, 1'b1);
        issue("divu",  5'h15, 32'd100, 32'd7, MDU ? 32'd14 : 32'h0, MDU ? 2'b00 : 2'b01, !MDU, LM, 1'b1);
        issue("remu",  5'h17, 32'd100, 32'd7, MDU ? 32'd2 : 32'h0, MDU ? 2'b00 : 2'b01, !MDU, LM, 1'b1);
        issue("mul",   5'h10, 32'hFFFFFFFD, 32'h00000005, MDU ? 32'hFFFFFFF1 : 32'h0, MDU ? 2'b00 : 2'b01, !MDU, LM, 1'b1);
        issue("mulh",  5'h11, 32'hFFFFFFFD, 32'h00000005, MDU ? 32'hFFFFFFFF : 32'h0, MDU ? 2'b00 : 2'b01, !MDU, LM, 1'b1);
        issue("mulhsu", 5'h12, 32'hFFFFFFFF, 32'hFFFFFFFF, MDU ? 32'hFFFFFFFF : 32'h0, MDU ? 2'b00 : 2'b01, !MDU, LM, 1'b1);
        drain();

        // Back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue("mulhu", 5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, MDU ? 32'hFFFFFFFE : 32'h0, MDU ? 2'b00 : 2'b01, !MDU, LM, 1'b1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold.result", result, MDU ? 32'hFFFFFFFE : 32'h0);
            chk("hold.out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold.in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();

        // Flush in the middle of a divide.
        issue("divfl", 5'h14, 32'hFFFFFFF9, 32'h00000002, 32'h0, 2'b01, 1'b1, 0, !MDU);
        t0 = cyc;
        while (cyc < t0 + 9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
`ifdef ALU_MC_MDU_EN
        rose = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        chk("flush.never_valid", {31'd0, rose}, 32'd0);
`endif
        drain();

        // Reset in the middle of a divide.
        issue("divrst", 5'h14, 32'hFFFFFFF9, 32'h00000002, 32'h0, 2'b01, 1'b1, 0, !MDU);
        t0 = cyc;
        while (cyc < t0 + 9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2.result", result, 32'd0);
        chk("rst2.status", {30'd0, status}, 32'd0);
        chk("rst2.illegal", {31'd0, illegal}, 32'd0);
        chk("rst2.in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        issue("add2", 5'h00, 32'd5, 32'd7, 32'd12, 2'b00, 1'b0, 0, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
